// File: rtl/ttm4_ctrl_pkg.sv
// ttm4_ctrl_pkg
//   Shared types for the TTM4 control unit: sequencer phase encoding,
//   4-bit opcode constants, bus source / destination selects and the
//   decoded-instruction bundle passed from the decoder to the sequencer.
`timescale 1ns/1ps
package ttm4_ctrl_pkg;

   // Encoding is visible on the STATE port, so values are fixed.
   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_READ  = 2'b01,
      ST_EXEC  = 2'b10,
      ST_PCUPD = 2'b11
   } state_e;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;  // A + Im -> A
   localparam logic [3:0] OP_MOV_AB = 4'b0001;  // B + Im -> A
   localparam logic [3:0] OP_IN_A   = 4'b0010;  // IN + Im -> A
   localparam logic [3:0] OP_MOV_AI = 4'b0011;  // 0 + Im -> A
   localparam logic [3:0] OP_MOV_BA = 4'b0100;  // A + Im -> B
   localparam logic [3:0] OP_ADD_B  = 4'b0101;  // B + Im -> B
   localparam logic [3:0] OP_IN_B   = 4'b0110;  // IN + Im -> B
   localparam logic [3:0] OP_MOV_BI = 4'b0111;  // 0 + Im -> B
   localparam logic [3:0] OP_OUT_B  = 4'b1001;  // B + Im -> OUT
   localparam logic [3:0] OP_OUT_I  = 4'b1011;  // 0 + Im -> OUT
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_JMP    = 4'b1111;

   // SRC_NONE leaves every bus driver off, so the bus reads 0.
   typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_IN} src_e;
   typedef enum logic [1:0] {DST_NONE, DST_A, DST_B, DST_OUT} dst_e;

   typedef struct packed {
      src_e src;
      dst_e dst;
      logic is_jmp;
      logic is_jnc;
      logic upd_carry;
      logic illegal;
   } dec_t;

endpackage

// File: rtl/ttm4_opcode_decode.sv
// ttm4_opcode_decode
//   Purely combinational opcode decoder.
//   Ports:
//     opcode  in  4      instruction bits [7:4]
//     dec     out dec_t  bus source, destination, jump kind, carry update, illegal
`timescale 1ns/1ps
module ttm4_opcode_decode
   import ttm4_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output dec_t       dec
);

   always_comb begin
      dec.src       = SRC_NONE;
      dec.dst       = DST_NONE;
      dec.is_jmp    = 1'b0;
      dec.is_jnc    = 1'b0;
      dec.upd_carry = 1'b1;
      dec.illegal   = 1'b0;
      case (opcode)
         OP_ADD_A:  begin dec.src = SRC_A;    dec.dst = DST_A;   end
         OP_MOV_AB: begin dec.src = SRC_B;    dec.dst = DST_A;   end
         OP_IN_A:   begin dec.src = SRC_IN;   dec.dst = DST_A;   end
         OP_MOV_AI: begin dec.src = SRC_NONE; dec.dst = DST_A;   end
         OP_MOV_BA: begin dec.src = SRC_A;    dec.dst = DST_B;   end
         OP_ADD_B:  begin dec.src = SRC_B;    dec.dst = DST_B;   end
         OP_IN_B:   begin dec.src = SRC_IN;   dec.dst = DST_B;   end
         OP_MOV_BI: begin dec.src = SRC_NONE; dec.dst = DST_B;   end
         OP_OUT_B:  begin dec.src = SRC_B;    dec.dst = DST_OUT; end
         OP_OUT_I:  begin dec.src = SRC_NONE; dec.dst = DST_OUT; end
         // Jumps use the immediate only; the carry flag is their input, not a result.
         OP_JMP:    begin dec.is_jmp = 1'b1;  dec.upd_carry = 1'b0; end
         OP_JNC:    begin dec.is_jnc = 1'b1;  dec.upd_carry = 1'b0; end
         // 1000/1010/1100/1101: behave as NOP, flag untouched.
         default:   begin dec.illegal = 1'b1; dec.upd_carry = 1'b0; end
      endcase
   end

endmodule

// File: rtl/ttm4_sequencer.sv
// ttm4_sequencer
//   Multi-cycle control unit of the TTM4 4-bit CPU. Each instruction walks
//   FETCH -> READ -> EXEC -> PCUPD; all control outputs are flops loaded with
//   the value wanted in the phase being entered.
//   Parameters: FETCH_WAIT (0..3 extra FETCH cycles), CFLAG_INIT (flag after reset).
//   Optional feature macro: SINGLE_STEP_EN (adds STEP input for single stepping).
//   Ports:
//     CLK, RST           clock (rising edge), async active-low reset
//     STEP               single-step request (SINGLE_STEP_EN only)
//     RUN                1 = run, 0 = hold in FETCH
//     INSTR[7:0]         ROM data, [7:4] opcode, [3:0] immediate
//     CARRY              ALU carry-out, sampled at the end of EXEC
//     IMM[3:0]           latched immediate
//     nA_OUT/nB_OUT/nIN_OUT  bus source enables (active-low)
//     nA_ST/nB_ST/nOUT_ST    destination load strobes (active-low)
//     nPC_LD, PC_INC     PC load (active-low) / count enable
//     CFLAG, STATE[1:0], ILLEGAL
`timescale 1ns/1ps
module ttm4_sequencer
   import ttm4_ctrl_pkg::*;
#(
   parameter int unsigned FETCH_WAIT = 0,
   parameter logic        CFLAG_INIT = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
`ifdef SINGLE_STEP_EN
   input  logic       STEP,
`endif
   input  logic       RUN,
   input  logic [7:0] INSTR,
   input  logic       CARRY,
   output logic [3:0] IMM,
   output logic       nA_OUT,
   output logic       nB_OUT,
   output logic       nIN_OUT,
   output logic       nA_ST,
   output logic       nB_ST,
   output logic       nOUT_ST,
   output logic       nPC_LD,
   output logic       PC_INC,
   output logic       CFLAG,
   output logic [1:0] STATE,
   output logic       ILLEGAL
);

   localparam logic [1:0] WAIT_MAX = 2'(FETCH_WAIT);

   state_e     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [1:0] wait_q, wait_d;
   logic       cflag_q, cflag_d;
   logic       n_a_out_q, n_a_out_d, n_b_out_q, n_b_out_d, n_in_out_q, n_in_out_d;
   logic       n_a_st_q, n_a_st_d, n_b_st_q, n_b_st_d, n_out_st_q, n_out_st_d;
   logic       n_pc_ld_q, n_pc_ld_d, pc_inc_q, pc_inc_d, illegal_q, illegal_d;
   logic       go;
   logic       take_jmp;
   dec_t       dec;

   // Decode the IR value being loaded this cycle, so the READ-phase bus
   // enable can be registered on the same edge that captures the instruction.
   ttm4_opcode_decode u_dec (
      .opcode (ir_d[7:4]),
      .dec    (dec)
   );

`ifdef SINGLE_STEP_EN
   logic step_meta_q, step_meta_d, step_sync_q, step_sync_d;
   logic step_prev_q, step_prev_d, step_pend_q, step_pend_d;
   logic leave_fetch;

   assign leave_fetch = (state_q == ST_FETCH) && (state_d == ST_READ);

   // A STEP edge is remembered until FETCH is left, so a step arriving
   // during the ROM wait count is not lost.
   always_comb begin
      step_meta_d = STEP;
      step_sync_d = step_meta_q;
      step_prev_d = step_sync_q;
      step_pend_d = step_pend_q | (step_sync_q & ~step_prev_q & ~RUN);
      if (leave_fetch) step_pend_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         step_meta_q <= 1'b0;
         step_sync_q <= 1'b0;
         step_prev_q <= 1'b0;
         step_pend_q <= 1'b0;
      end else begin
         step_meta_q <= step_meta_d;
         step_sync_q <= step_sync_d;
         step_prev_q <= step_prev_d;
         step_pend_q <= step_pend_d;
      end
   end

   assign go = RUN | step_pend_q;
`else
   assign go = RUN;
`endif

   // JNC looks at the flag as it stands; jumps never modify it.
   assign take_jmp = dec.is_jmp | (dec.is_jnc & ~cflag_q);

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      wait_d     = wait_q;
      cflag_d    = cflag_q;
      n_a_out_d  = 1'b1;
      n_b_out_d  = 1'b1;
      n_in_out_d = 1'b1;
      n_a_st_d   = 1'b1;
      n_b_st_d   = 1'b1;
      n_out_st_d = 1'b1;
      n_pc_ld_d  = 1'b1;
      pc_inc_d   = 1'b0;
      illegal_d  = 1'b0;

      case (state_q)
         ST_FETCH: begin
            if (!go) begin
               wait_d = 2'd0;
            end else if (wait_q == WAIT_MAX) begin
               wait_d  = 2'd0;
               ir_d    = INSTR;
               state_d = ST_READ;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         ST_READ:  state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_PCUPD;
            if (dec.upd_carry) cflag_d = CARRY;
         end
         default:  state_d = ST_FETCH;
      endcase

      // Output flops carry the value for the phase being entered.
      if (state_d == ST_READ || state_d == ST_EXEC) begin
         n_a_out_d  = (dec.src != SRC_A);
         n_b_out_d  = (dec.src != SRC_B);
         n_in_out_d = (dec.src != SRC_IN);
      end
      if (state_d == ST_EXEC) begin
         n_a_st_d   = (dec.dst != DST_A);
         n_b_st_d   = (dec.dst != DST_B);
         n_out_st_d = (dec.dst != DST_OUT);
         illegal_d  = dec.illegal;
      end
      if (state_d == ST_PCUPD) begin
         n_pc_ld_d = ~take_jmp;
         pc_inc_d  = ~take_jmp;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= ST_FETCH;
         ir_q       <= 8'h00;
         wait_q     <= 2'd0;
         cflag_q    <= CFLAG_INIT;
         n_a_out_q  <= 1'b1;
         n_b_out_q  <= 1'b1;
         n_in_out_q <= 1'b1;
         n_a_st_q   <= 1'b1;
         n_b_st_q   <= 1'b1;
         n_out_st_q <= 1'b1;
         n_pc_ld_q  <= 1'b1;
         pc_inc_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         wait_q     <= wait_d;
         cflag_q    <= cflag_d;
         n_a_out_q  <= n_a_out_d;
         n_b_out_q  <= n_b_out_d;
         n_in_out_q <= n_in_out_d;
         n_a_st_q   <= n_a_st_d;
         n_b_st_q   <= n_b_st_d;
         n_out_st_q <= n_out_st_d;
         n_pc_ld_q  <= n_pc_ld_d;
         pc_inc_q   <= pc_inc_d;
         illegal_q  <= illegal_d;
      end
   end

   assign IMM     = ir_q[3:0];
   assign nA_OUT  = n_a_out_q;
   assign nB_OUT  = n_b_out_q;
   assign nIN_OUT = n_in_out_q;
   assign nA_ST   = n_a_st_q;
   assign nB_ST   = n_b_st_q;
   assign nOUT_ST = n_out_st_q;
   assign nPC_LD  = n_pc_ld_q;
   assign PC_INC  = pc_inc_q;
   assign CFLAG   = cflag_q;
   assign STATE   = state_q;
   assign ILLEGAL = illegal_q;

   a_bus_onehot: assert property (@(posedge CLK) disable iff (!RST)
      $countones({~nA_OUT, ~nB_OUT, ~nIN_OUT}) <= 1);
   a_st_onehot: assert property (@(posedge CLK) disable iff (!RST)
      $countones({~nA_ST, ~nB_ST, ~nOUT_ST}) <= 1);
   a_pc_excl: assert property (@(posedge CLK) disable iff (!RST)
      !(PC_INC && !nPC_LD));
`ifndef SINGLE_STEP_EN
   a_run_hold: assert property (@(posedge CLK) disable iff (!RST)
      (state_q == ST_FETCH && !RUN) |=> (state_q == ST_FETCH));
`endif

endmodule

// File: tb/tb_ttm4_sequencer.sv
`timescale 1ns/1ps
module tb_ttm4_sequencer;

   localparam logic CF_INIT = 1'b0;
   localparam int S_0 = 0, S_A = 1, S_B = 2, S_IN = 3;
   localparam int D_NONE = 0, D_A = 1, D_B = 2, D_OUT = 3;
   localparam int K_NORM = 0, K_JMP = 1, K_JNC = 2, K_ILL = 3;

   logic       CLK = 1'b0, RST = 1'b0, RUN = 1'b0, CARRY = 1'b0;
   logic [7:0] INSTR = 8'h00;
   logic [3:0] IMM, IMM2;
   logic       nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC, CFLAG, ILLEGAL;
   logic       nA_OUT2, nB_OUT2, nIN_OUT2, nA_ST2, nB_ST2, nOUT_ST2, nPC_LD2, PC_INC2, CFLAG2, ILLEGAL2;
   logic [1:0] STATE, STATE2;

   int         tests = 0, fails = 0;
   logic       cf_m = CF_INIT;
   logic [3:0] imm_m = 4'h0;
   int         src_tab [16], dst_tab [16], kind_tab [16];

   always #5 CLK = ~CLK;

   ttm4_sequencer #(.FETCH_WAIT(0), .CFLAG_INIT(CF_INIT)) dut (
      .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .CARRY(CARRY), .IMM(IMM),
      .nA_OUT(nA_OUT), .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT), .nA_ST(nA_ST), .nB_ST(nB_ST),
      .nOUT_ST(nOUT_ST), .nPC_LD(nPC_LD), .PC_INC(PC_INC), .CFLAG(CFLAG), .STATE(STATE),
      .ILLEGAL(ILLEGAL));

   ttm4_sequencer #(.FETCH_WAIT(2), .CFLAG_INIT(CF_INIT)) dut2 (
      .CLK(CLK), .RST(RST), .RUN(RUN), .INSTR(INSTR), .CARRY(CARRY), .IMM(IMM2),
      .nA_OUT(nA_OUT2), .nB_OUT(nB_OUT2), .nIN_OUT(nIN_OUT2), .nA_ST(nA_ST2), .nB_ST(nB_ST2),
      .nOUT_ST(nOUT_ST2), .nPC_LD(nPC_LD2), .PC_INC(PC_INC2), .CFLAG(CFLAG2), .STATE(STATE2),
      .ILLEGAL(ILLEGAL2));

   // {STATE, nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC, CFLAG, ILLEGAL, IMM}
   function automatic logic [15:0] obs_now();
      return {STATE, nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC,
              CFLAG, ILLEGAL, IMM};
   endfunction

   task automatic set_op(input int op, input int s, input int d, input int k);
      src_tab[op] = s; dst_tab[op] = d; kind_tab[op] = k;
   endtask

   task automatic load_tables();
      for (int i = 0; i < 16; i++) set_op(i, S_0, D_NONE, K_ILL);
      set_op(4'b0000, S_A,  D_A,   K_NORM);
      set_op(4'b0101, S_B,  D_B,   K_NORM);
      set_op(4'b0011, S_0,  D_A,   K_NORM);
      set_op(4'b0111, S_0,  D_B,   K_NORM);
      set_op(4'b0001, S_B,  D_A,   K_NORM);
      set_op(4'b0100, S_A,  D_B,   K_NORM);
      set_op(4'b0010, S_IN, D_A,   K_NORM);
      set_op(4'b0110, S_IN, D_B,   K_NORM);
      set_op(4'b1001, S_B,  D_OUT, K_NORM);
      set_op(4'b1011, S_0,  D_OUT, K_NORM);
      set_op(4'b1111, S_0,  D_NONE, K_JMP);
      set_op(4'b1110, S_0,  D_NONE, K_JNC);
   endtask

   // Expected outputs in phase ph (0 READ, 1 EXEC, 2 PCUPD, 3 back in FETCH).
   function automatic logic [15:0] exp_vec(input logic [7:0] ins, input int ph,
                                           input logic cf_old, input logic c);
      int s, d, k;
      logic bus, take, cf_new, cf;
      logic [1:0] st;
      s = src_tab[ins[7:4]]; d = dst_tab[ins[7:4]]; k = kind_tab[ins[7:4]];
      cf_new = (k == K_NORM) ? c : cf_old;
      take   = (k == K_JMP) || (k == K_JNC && !cf_old);
      bus    = (ph <= 1);
      st     = (ph == 3) ? 2'd0 : 2'(ph + 1);
      cf     = (ph >= 2) ? cf_new : cf_old;
      return {st, !(bus && s == S_A), !(bus && s == S_B), !(bus && s == S_IN),
              !(ph == 1 && d == D_A), !(ph == 1 && d == D_B), !(ph == 1 && d == D_OUT),
              !(ph == 2 && take), (ph == 2 && !take), cf, (ph == 1 && k == K_ILL), ins[3:0]};
   endfunction

   // Called at a negedge with the DUT in FETCH; captures the four following phases.
   task automatic step_instr(input logic [7:0] ins, input logic c, output logic [3:0][15:0] obs);
      INSTR = ins; CARRY = c; RUN = 1'b1;
      for (int p = 0; p < 4; p++) begin
         @(posedge CLK); @(negedge CLK);
         obs[p] = obs_now();
      end
   endtask

   task automatic test_reset();
      logic [15:0] exp;
      exp = {2'b00, 7'h7F, 1'b0, CF_INIT, 1'b0, 4'h0};
      RST = 1'b0; RUN = 1'b0;
      repeat (3) @(negedge CLK);
      tests++;
      if (obs_now() !== exp) begin
         fails++; $display("FAIL reset_held got %h exp %h", obs_now(), exp);
      end
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      tests++;
      if (obs_now() !== exp) begin
         fails++; $display("FAIL reset_idle got %h exp %h", obs_now(), exp);
      end
      cf_m = CF_INIT; imm_m = 4'h0;
   endtask

   task automatic test_mov_add();
      logic [7:0] ins [2] = '{8'h35, 8'h0C};
      logic       c   [2] = '{1'b0, 1'b1};
      logic [3:0][15:0] obs;
      logic [15:0] exp;
      for (int i = 0; i < 2; i++) begin
         step_instr(ins[i], c[i], obs);
         for (int p = 0; p < 4; p++) begin
            exp = exp_vec(ins[i], p, cf_m, c[i]); tests++;
            if (obs[p] !== exp) begin
               fails++; $display("FAIL mov_add i%0d ph%0d got %h exp %h", i, p, obs[p], exp);
            end
         end
         cf_m = exp[5]; imm_m = ins[i][3:0];
      end
      RUN = 1'b0;
      tests++;
      if (CFLAG !== 1'b1) begin
         fails++; $display("FAIL mov_add_cflag got %b exp 1", CFLAG);
      end
   endtask

   task automatic test_moves();
      logic [7:0] ins [7] = '{8'h40, 8'h1F, 8'h2A, 8'h6B, 8'h93, 8'hB4, 8'h58};
      logic [3:0][15:0] obs;
      logic [15:0] exp;
      logic c;
      for (int i = 0; i < 7; i++) begin
         c = 1'($urandom);
         step_instr(ins[i], c, obs);
         for (int p = 0; p < 4; p++) begin
            exp = exp_vec(ins[i], p, cf_m, c); tests++;
            if (obs[p] !== exp) begin
               fails++; $display("FAIL moves %h ph%0d got %h exp %h", ins[i], p, obs[p], exp);
            end
         end
         cf_m = exp[5]; imm_m = ins[i][3:0];
      end
      RUN = 1'b0;
   endtask

   task automatic test_jumps();
      logic [7:0] ins [5] = '{8'h00, 8'hE7, 8'h00, 8'hE7, 8'hF3};
      logic       c   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0][15:0] obs;
      logic [15:0] exp;
      for (int i = 0; i < 5; i++) begin
         step_instr(ins[i], c[i], obs);
         for (int p = 0; p < 4; p++) begin
            exp = exp_vec(ins[i], p, cf_m, c[i]); tests++;
            if (obs[p] !== exp) begin
               fails++; $display("FAIL jumps i%0d ph%0d got %h exp %h", i, p, obs[p], exp);
            end
         end
         cf_m = exp[5]; imm_m = ins[i][3:0];
      end
      RUN = 1'b0;
   endtask

   task automatic test_illegal();
      logic [7:0] ins [4] = '{8'h80, 8'hA5, 8'hC3, 8'hD9};
      logic [3:0][15:0] obs;
      logic [15:0] exp;
      logic c;
      for (int i = 0; i < 4; i++) begin
         c = ~cf_m;  // a carry update here would be visible
         step_instr(ins[i], c, obs);
         for (int p = 0; p < 4; p++) begin
            exp = exp_vec(ins[i], p, cf_m, c); tests++;
            if (obs[p] !== exp) begin
               fails++; $display("FAIL illegal %h ph%0d got %h exp %h", ins[i], p, obs[p], exp);
            end
         end
         cf_m = exp[5]; imm_m = ins[i][3:0];
      end
      RUN = 1'b0;
   endtask

   task automatic test_run_hold();
      logic [15:0] exp;
      RUN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         INSTR = 8'($urandom); CARRY = 1'($urandom);
         @(negedge CLK);
         exp = {2'b00, 7'h7F, 1'b0, cf_m, 1'b0, imm_m}; tests++;
         if (obs_now() !== exp) begin
            fails++; $display("FAIL run_hold c%0d got %h exp %h", i, obs_now(), exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0][15:0] obs;
      logic [15:0] exp;
      logic [7:0] ins;
      logic c;
      for (int i = 0; i < 40; i++) begin
         ins = 8'($urandom); c = 1'($urandom);
         step_instr(ins, c, obs);
         for (int p = 0; p < 4; p++) begin
            exp = exp_vec(ins, p, cf_m, c); tests++;
            if (obs[p] !== exp) begin
               fails++; $display("FAIL b2b i%0d %h ph%0d got %h exp %h", i, ins, p, obs[p], exp);
            end
         end
         cf_m = exp[5]; imm_m = ins[3:0];
      end
      RUN = 1'b0;
   endtask

   task automatic test_reset_mid_exec();
      logic [15:0] exp;
      exp = {2'b00, 7'h7F, 1'b0, CF_INIT, 1'b0, 4'h0};
      INSTR = 8'h3A; CARRY = ~CF_INIT; RUN = 1'b1;
      @(posedge CLK); @(posedge CLK);  // now in EXEC
      #2 RST = 1'b0;
      #1;
      tests++;
      if (obs_now() !== exp) begin
         fails++; $display("FAIL reset_mid_exec got %h exp %h", obs_now(), exp);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK); tests++;
         if (nA_ST !== 1'b1 || STATE !== 2'b00) begin
            fails++; $display("FAIL reset_mid_exec_hold nA_ST %b STATE %b exp 1 00", nA_ST, STATE);
         end
      end
      RUN = 1'b0; RST = 1'b1;
      cf_m = CF_INIT; imm_m = 4'h0;
   endtask

   task automatic test_fetch_wait();
      int t1 [2] = '{0, 0};
      int t2 [2] = '{0, 0};
      int n1 = 0, n2 = 0, st_low2 = 0;
      logic [1:0] p1 = 2'b00, p2 = 2'b00;
      RUN = 1'b0; RST = 1'b0;
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK);
      INSTR = 8'h35; CARRY = 1'b0; RUN = 1'b1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         @(posedge CLK); @(negedge CLK);
         if (STATE == 2'b01 && p1 != 2'b01 && n1 < 2) begin t1[n1] = cyc; n1++; end
         if (STATE2 == 2'b01 && p2 != 2'b01 && n2 < 2) begin t2[n2] = cyc; n2++; end
         if (n2 == 1 && !nA_ST2) st_low2++;
         p1 = STATE; p2 = STATE2;
      end
      RUN = 1'b0;
      tests++;
      if (t1[0] !== 1) begin fails++; $display("FAIL fw0_first got %0d exp 1", t1[0]); end
      tests++;
      if (t1[1] - t1[0] !== 4) begin fails++; $display("FAIL fw0_period got %0d exp 4", t1[1] - t1[0]); end
      tests++;
      if (t2[0] !== 3) begin fails++; $display("FAIL fw2_first got %0d exp 3", t2[0]); end
      tests++;
      if (t2[1] - t2[0] !== 6) begin fails++; $display("FAIL fw2_period got %0d exp 6", t2[1] - t2[0]); end
      tests++;
      if (st_low2 !== 1) begin fails++; $display("FAIL fw2_strobe got %0d exp 1", st_low2); end
      RST = 1'b0;
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK);
      cf_m = CF_INIT; imm_m = 4'h0;
   endtask

   initial begin
      load_tables();
      test_reset();
      test_mov_add();
      test_moves();
      test_jumps();
      test_illegal();
      test_run_hold();
      test_back_to_back();
      test_reset_mid_exec();
      test_fetch_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
